// File: rtl/spi_bus_bridge.sv
// SPI mode-0 slave that turns 16-bit command/data frames into parallel-bus write or read cycles.
// Every SPI input is brought into the clk domain; the FSM sequences ce/rw/data around the frame.
module spi_bus_bridge #(
  parameter int NUM_CE        = 4,
  parameter int STROBE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sclk,
  input  logic              nss,
  input  logic              mosi,
  output logic              miso,
  output logic [NUM_CE-1:0] ce,
  output logic              rw,
  inout  wire  [7:0]        data
);
  localparam int CW = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;

  typedef enum logic [2:0] {
    IDLE, W_SETUP, W_STROBE, W_HOLD, R_SETUP, R_STROBE, R_DONE
  } state_t;

  state_t          state;
  logic            sclk_meta, sclk_sync, sclk_d;
  logic            nss_meta, nss_sync, nss_d;
  logic            mosi_meta, mosi_sync;
  logic [4:0]      bit_cnt;
  logic [6:0]      rx_sr;
  logic [7:0]      cmd;
  logic [7:0]      tx_sr;
  logic            miso_r;
  logic [CW-1:0]   strobe_cnt;
  logic [6:0]      bus_addr;
  logic [7:0]      data_out;
  logic            data_oe;
  logic [7:0]      rd_byte;

  function automatic logic [NUM_CE-1:0] decode(input logic [6:0] a);
    logic [NUM_CE-1:0] d;
    d = '0;
    for (int i = 0; i < NUM_CE; i++) d[i] = (a == 7'(i));
    return d;
  endfunction

  logic       sclk_rise, sclk_fall, nss_rise, nss_fall, bit_take;
  logic [7:0] next_byte;
  logic       read_go, write_go;

  // An edge belongs to the frame when the previous synced nss was low, so the
  // 16th edge still counts if nss rises on the very same cycle.
  always_comb begin
    sclk_rise = sclk_sync & ~sclk_d;
    sclk_fall = ~sclk_sync & sclk_d;
    nss_rise  = nss_sync & ~nss_d;
    nss_fall  = ~nss_sync & nss_d;
    bit_take  = sclk_rise & ~nss_d & (bit_cnt < 5'd16);
    next_byte = {rx_sr, mosi_sync};
    read_go   = bit_take & (bit_cnt == 5'd7) & next_byte[7] & (state == IDLE);
    write_go  = bit_take & (bit_cnt == 5'd15) & ~cmd[7] & (|decode(cmd[6:0]))
                & (state == IDLE);
  end

  assign data = data_oe ? data_out : 8'bz;
  assign miso = nss_sync ? 1'bz : miso_r;

  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_meta  <= 1'b0;
      sclk_sync  <= 1'b0;
      sclk_d     <= 1'b0;
      nss_meta   <= 1'b1;
      nss_sync   <= 1'b1;
      nss_d      <= 1'b1;
      mosi_meta  <= 1'b0;
      mosi_sync  <= 1'b0;
      bit_cnt    <= '0;
      rx_sr      <= '0;
      cmd        <= '0;
      tx_sr      <= '0;
      miso_r     <= 1'b0;
      state      <= IDLE;
      strobe_cnt <= '0;
      bus_addr   <= '0;
      data_out   <= '0;
      data_oe    <= 1'b0;
      rd_byte    <= '0;
      ce         <= '0;
      rw         <= 1'b1;
    end else begin
      sclk_meta <= sclk;
      sclk_sync <= sclk_meta;
      sclk_d    <= sclk_sync;
      nss_meta  <= nss;
      nss_sync  <= nss_meta;
      nss_d     <= nss_sync;
      mosi_meta <= mosi;
      mosi_sync <= mosi_meta;

      if (nss_fall) begin
        bit_cnt <= '0;
        rx_sr   <= '0;
        tx_sr   <= '0;
        miso_r  <= 1'b0;
      end else begin
        if (bit_take) begin
          rx_sr   <= next_byte[6:0];
          bit_cnt <= bit_cnt + 5'd1;
          if (bit_cnt == 5'd7) cmd <= next_byte;
        end
        if (nss_rise) begin
          bit_cnt <= '0;
          rx_sr   <= '0;
        end
        if (sclk_fall && !nss_sync) begin
          miso_r <= tx_sr[7];
          tx_sr  <= {tx_sr[6:0], 1'b0};
        end
        if (state == R_DONE) tx_sr <= rd_byte;
      end

      case (state)
        IDLE: begin
          if (write_go) begin
            bus_addr <= cmd[6:0];
            data_out <= next_byte;
            data_oe  <= 1'b1;
            rw       <= 1'b0;
            ce       <= '0;
            state    <= W_SETUP;
          end else if (read_go) begin
            bus_addr <= next_byte[6:0];
            data_oe  <= 1'b0;
            rw       <= 1'b1;
            ce       <= '0;
            state    <= R_SETUP;
          end
        end
        W_SETUP: begin
          ce         <= decode(bus_addr);
          strobe_cnt <= CW'(STROBE_CYCLES - 1);
          state      <= W_STROBE;
        end
        W_STROBE: begin
          if (strobe_cnt == '0) begin
            ce    <= '0;
            state <= W_HOLD;
          end else begin
            strobe_cnt <= strobe_cnt - 1'b1;
          end
        end
        W_HOLD: begin
          data_oe <= 1'b0;
          rw      <= 1'b1;
          state   <= IDLE;
        end
        R_SETUP: begin
          ce         <= decode(bus_addr);
          strobe_cnt <= CW'(STROBE_CYCLES - 1);
          state      <= R_STROBE;
        end
        R_STROBE: begin
          if (strobe_cnt == '0) begin
            // Unmapped addresses read as zero rather than a floating bus.
            rd_byte <= (|decode(bus_addr)) ? data : 8'h00;
            ce      <= '0;
            state   <= R_DONE;
          end else begin
            strobe_cnt <= strobe_cnt - 1'b1;
          end
        end
        R_DONE:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_bus_bridge.sv
// Bench for spi_bus_bridge: directed frames then random frames, checked against a
// register-file model of the peripherals plus a bus-cycle monitor.
module tb_spi_bus_bridge;
  localparam int NUM_CE = 4;
  localparam int HALF   = 10;

  logic              clk = 1'b0;
  logic              reset, sclk, nss, mosi;
  wire               miso;
  logic [NUM_CE-1:0] ce;
  logic              rw;
  wire  [7:0]        data;

  spi_bus_bridge #(.NUM_CE(NUM_CE), .STROBE_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .sclk(sclk), .nss(nss), .mosi(mosi),
    .miso(miso), .ce(ce), .rw(rw), .data(data)
  );

  // clock / reset
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // peripherals: a byte register per chip enable
  logic [7:0] periph_mem [NUM_CE];
  logic [7:0] periph_q;

  function automatic int ce_idx(input logic [NUM_CE-1:0] c);
    int r = 0;
    for (int i = 0; i < NUM_CE; i++) if (c[i]) r = i;
    return r;
  endfunction

  always_comb periph_q = periph_mem[ce_idx(ce)];
  assign data = (rw && ce != '0) ? periph_q : 8'bz;

  always @(negedge clk)
    if (!reset && ce != '0 && rw == 1'b0) periph_mem[ce_idx(ce)] <= data;

  // bus monitor
  typedef struct {
    int         addr;
    logic       rw;
    logic [7:0] d;
    int         width;
  } bus_rec_t;

  bus_rec_t          bus_q[$];
  bus_rec_t          exp_bus[$];
  logic [7:0]        exp_q[$];
  logic [NUM_CE-1:0] prev_ce;
  logic              prev_rw;
  logic [7:0]        prev_data;
  int                width, cur_addr;
  logic              cur_rw;
  logic [7:0]        cur_d;
  int                onehot_err = 0, overlap_err = 0, inv_err = 0, drive_cycles = 0;

  always @(negedge clk) begin
    if (reset) begin
      prev_ce <= '0;
      prev_rw <= 1'b1;
      prev_data <= data;
      width <= 0;
    end else begin
      if (rw == 1'b0) drive_cycles <= drive_cycles + 1;
      if (ce != '0) begin
        if ($countones(ce) != 1) onehot_err <= onehot_err + 1;
        if (prev_ce != '0 && ce != prev_ce) overlap_err <= overlap_err + 1;
        if (rw != prev_rw || (rw == 1'b0 && data !== prev_data)) inv_err <= inv_err + 1;
        width    <= width + 1;
        cur_addr <= ce_idx(ce);
        cur_rw   <= rw;
        cur_d    <= data;
      end else if (prev_ce != '0) begin
        if (rw != prev_rw || (prev_rw == 1'b0 && data !== prev_data)) inv_err <= inv_err + 1;
        bus_q.push_back('{cur_addr, cur_rw, cur_d, width});
        width <= 0;
      end
      prev_ce   <= ce;
      prev_rw   <= rw;
      prev_data <= data;
    end
  end

  // checking
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_bus(input string tag);
    bus_rec_t o, e;
    check({tag, " bus_cycles"}, bus_q.size(), exp_bus.size());
    while (bus_q.size() > 0 && exp_bus.size() > 0) begin
      o = bus_q.pop_front();
      e = exp_bus.pop_front();
      check({tag, " addr"}, o.addr, e.addr);
      check({tag, " rw"}, {31'b0, o.rw}, {31'b0, e.rw});
      check({tag, " data"}, {24'b0, o.d}, {24'b0, e.d});
      check({tag, " ce_width"}, o.width, e.width);
    end
    bus_q.delete();
    exp_bus.delete();
  endtask

  // reference model: what a frame should do to the bus and to MISO
  logic [7:0] ref_mem [NUM_CE];

  task automatic model_frame(input logic [15:0] v, input int nbits);
    logic       rd = v[15];
    int         a = int'(v[14:8]);
    logic [7:0] d = v[7:0];
    if (rd && nbits >= 8) begin
      if (a < NUM_CE) exp_bus.push_back('{a, 1'b1, ref_mem[a], 2});
      if (nbits >= 16) exp_q.push_back(a < NUM_CE ? ref_mem[a] : 8'h00);
    end else if (!rd && nbits >= 16) begin
      if (a < NUM_CE) begin
        exp_bus.push_back('{a, 1'b0, d, 2});
        ref_mem[a] = d;
      end
      exp_q.push_back(8'h00);
    end
  endtask

  // SPI master driver; returns the byte seen on MISO during the second byte
  task automatic spi_frame(input logic [15:0] v, input int nbits, input bit hold,
                           output logic [7:0] rd);
    rd = 8'h00;
    @(negedge clk);
    nss = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      mosi = (i < 16) ? v[15-i] : 1'($urandom_range(0, 1));
      repeat (HALF) @(negedge clk);
      if (i >= 8 && i < 16) rd = {rd[6:0], miso};
      sclk = 1'b1;
      if (!(hold && i == nbits - 1)) begin
        repeat (HALF) @(negedge clk);
        sclk = 1'b0;
      end
    end
    if (!hold) begin
      repeat (HALF) @(negedge clk);
      nss = 1'b1;
      repeat (2 * HALF) @(negedge clk);
    end
  endtask

  task automatic run_frame(input logic [15:0] v, input int nbits, input string tag);
    logic [7:0] rd;
    logic [7:0] e;
    model_frame(v, nbits);
    spi_frame(v, nbits, 1'b0, rd);
    if (nbits >= 16) begin
      e = exp_q.pop_front();
      check({tag, " miso_byte"}, {24'b0, rd}, {24'b0, e});
    end
    check_bus(tag);
  endtask

  initial begin
    logic [7:0] rd;
    int         got_ce;
    int         drv0;
    reset = 1'b1; sclk = 1'b0; nss = 1'b1; mosi = 1'b0;
    for (int i = 0; i < NUM_CE; i++) begin
      periph_mem[i] = 8'($urandom_range(0, 255));
      ref_mem[i]    = periph_mem[i];
    end
    repeat (3) @(negedge clk);
    check("reset ce", {28'b0, ce}, 32'h0);
    check("reset rw", {31'b0, rw}, 32'h1);
    check("reset data_z", {31'b0, data === 8'bz}, 32'h1);
    check("reset miso_z", {31'b0, miso === 1'bz}, 32'h1);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // reset in the middle of a write strobe
    spi_frame(16'h0277, 16, 1'b1, rd);
    got_ce = 0;
    for (int i = 0; i < 40 && got_ce == 0; i++) begin
      @(negedge clk);
      if (ce != '0) got_ce = 1;
    end
    check("midreset strobe_seen", got_ce, 1);
    reset = 1'b1;
    @(negedge clk);
    check("midreset ce", {28'b0, ce}, 32'h0);
    check("midreset rw", {31'b0, rw}, 32'h1);
    check("midreset data_z", {31'b0, data === 8'bz}, 32'h1);
    check("midreset miso_z", {31'b0, miso === 1'bz}, 32'h1);
    sclk = 1'b0; nss = 1'b1; mosi = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    ref_mem[2] = 8'h77;
    bus_q.delete();

    // write, then the bus returns to idle
    run_frame(16'h004F, 16, "write0");
    check("write0 idle data_z", {31'b0, data === 8'bz}, 32'h1);
    check("write0 idle rw", {31'b0, rw}, 32'h1);

    // read of a known peripheral value
    periph_mem[1] = 8'hA5; ref_mem[1] = 8'hA5;
    run_frame(16'h8100, 16, "read1");

    // unmapped address: no bus activity, reads return zero
    drv0 = drive_cycles;
    run_frame(16'h0533, 16, "badwrite");
    check("badwrite no_drive", drive_cycles - drv0, 0);
    check("badwrite data_z", {31'b0, data === 8'bz}, 32'h1);
    run_frame(16'h8500, 16, "badread");

    // aborted frame followed by a clean one
    run_frame(16'h02FF, 11, "abort");
    run_frame(16'h0211, 16, "after_abort");

    // back-to-back write then read of the same peripheral
    run_frame(16'h003C, 16, "b2b_write");
    run_frame(16'h8000, 16, "b2b_read");

    // extra clocks past 16 bits must not start another cycle
    run_frame(16'h03C7, 20, "long_write");
    run_frame(16'h8300, 20, "long_read");

    // random traffic
    for (int n = 0; n < 16; n++) begin
      logic [15:0] v;
      v = {1'($urandom_range(0, 1)), 7'($urandom_range(0, 5)), 8'($urandom_range(0, 255))};
      run_frame(v, 16, "random");
    end

    check("onehot errors", onehot_err, 0);
    check("overlap errors", overlap_err, 0);
    check("ce_stability errors", inv_err, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
